sd_block_arbiter: RTL and testbench

- Parametrised successor to the single-drive HDD request handler in the top-level core.
- Accepts per-drive read/write request pulses from up to VDNUM virtual block devices (floppy/HDD controllers).
- Latches the requests, arbitrates them round-robin onto hps_io's sd_rd/sd_wr/sd_lba vectors, and tracks the sd_ack handshake.
- Adds what the old handler lacked: mount/protect bookkeeping per drive, a CPU wait output, per-drive done/error pulses, write-protect rejection, and an ack timeout.

---
 rtl/sd_block_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_sd_block_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter for per-drive sector requests onto the hps_io sd_rd/sd_wr/sd_lba handshake,
// with mount/protect bookkeeping, CPU wait, done/error pulses and an ack timeout.
module sd_block_arbiter #(
    parameter int VDNUM     = 2,
    parameter int LBA_W     = 32,
    parameter int TIMEOUT_W = 24
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [VDNUM-1:0]       req_rd,
    input  logic [VDNUM-1:0]       req_wr,
    input  logic [VDNUM*LBA_W-1:0] req_lba,
    input  logic [VDNUM-1:0]       img_mounted,
    input  logic                   img_readonly,
    input  logic                   img_size_nz,
    input  logic [VDNUM-1:0]       sd_ack,
    output logic [VDNUM-1:0]       sd_rd,
    output logic [VDNUM-1:0]       sd_wr,
    output logic [VDNUM*LBA_W-1:0] sd_lba,
    output logic [VDNUM-1:0]       mounted,
    output logic [VDNUM-1:0]       protect,
    output logic [VDNUM-1:0]       busy,
    output logic                   cpu_wait,
    output logic [VDNUM-1:0]       done,
    output logic [VDNUM-1:0]       err
);
    localparam int SEL_W = (VDNUM > 1) ? $clog2(VDNUM) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

    state_t                 r_state;
    logic [SEL_W-1:0]       r_sel;
    logic [SEL_W-1:0]       r_ptr;
    logic                   r_op_wr;
    logic [TIMEOUT_W-1:0]   r_timer;
    logic [VDNUM-1:0]       r_pend_rd;
    logic [VDNUM-1:0]       r_pend_wr;
    logic [VDNUM-1:0]       r_mounted;
    logic [VDNUM-1:0]       r_protect;
    logic [VDNUM-1:0]       r_ack_prev;
    logic [VDNUM-1:0]       r_sd_rd;
    logic [VDNUM-1:0]       r_sd_wr;
    logic [VDNUM-1:0]       r_done;
    logic [VDNUM-1:0]       r_err;
    logic [VDNUM*LBA_W-1:0] r_sd_lba;

    logic [VDNUM-1:0] w_active;
    logic [VDNUM-1:0] w_busy;
    logic [VDNUM-1:0] w_acc_rd;
    logic [VDNUM-1:0] w_acc_wr;
    logic [VDNUM-1:0] w_rej;
    logic [VDNUM-1:0] w_unmnt_err;
    logic [VDNUM-1:0] w_clr_rd;
    logic [VDNUM-1:0] w_clr_wr;
    logic [VDNUM-1:0] w_tmo_err;
    logic [SEL_W:0]   w_pick;
    logic             w_pick_rd;
    logic             w_ack_rise;
    logic             w_ack_fall;
    logic             w_tmo;
    logic             w_clr_op;

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] s);
        if (int'(s) == VDNUM - 1)
            return '0;
        return s + 1'b1;
    endfunction

    // {found, index}: first pending drive at or after ptr, wrapping
    function automatic logic [SEL_W:0] rr_pick(input logic [VDNUM-1:0] pend,
                                               input logic [SEL_W-1:0] ptr);
        logic [VDNUM-1:0] rot;
        int               idx;
        rr_pick = '0;
        for (int k = VDNUM - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % VDNUM;
            rot = pend >> idx;
            if (rot[0])
                rr_pick = {1'b1, SEL_W'(idx)};
        end
    endfunction

    always_comb begin
        w_active = '0;
        if (r_state != IDLE)
            w_active[r_sel] = 1'b1;
    end

    assign w_busy      = r_pend_rd | r_pend_wr | w_active;
    assign w_acc_rd    = req_rd & r_mounted & ~w_busy;
    assign w_acc_wr    = req_wr & r_mounted & ~r_protect & ~w_busy;
    assign w_rej       = ((req_rd | req_wr) & ~r_mounted) | (req_wr & r_mounted & r_protect);
    assign w_unmnt_err = img_mounted & ~{VDNUM{img_size_nz}}
                       & (r_pend_rd | r_pend_wr | w_acc_rd | w_acc_wr);

    assign w_pick     = rr_pick(r_pend_rd | r_pend_wr, r_ptr);
    assign w_pick_rd  = r_pend_rd[w_pick[SEL_W-1:0]];
    assign w_ack_rise = (r_state == ISSUE) && sd_ack[r_sel] && !r_ack_prev[r_sel];
    assign w_ack_fall = (r_state == XFER) && !sd_ack[r_sel] && r_ack_prev[r_sel];
    assign w_tmo      = (r_state != IDLE) && (r_timer == '1) && !w_ack_rise && !w_ack_fall;
    assign w_clr_op   = w_ack_rise || (w_tmo && r_state == ISSUE);

    always_comb begin
        w_clr_rd  = '0;
        w_clr_wr  = '0;
        w_tmo_err = '0;
        if (w_clr_op) begin
            if (r_op_wr)
                w_clr_wr[r_sel] = 1'b1;
            else
                w_clr_rd[r_sel] = 1'b1;
        end
        w_tmo_err[r_sel] = w_tmo;
    end

    // Per-drive bookkeeping: mount state, pending flags, latched sector, error pulses
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mounted <= '0;
            r_protect <= '0;
            r_pend_rd <= '0;
            r_pend_wr <= '0;
            r_sd_lba  <= '0;
            r_err     <= '0;
        end else begin
            for (int i = 0; i < VDNUM; i++) begin
                if (img_mounted[i]) begin
                    r_mounted[i] <= img_size_nz;
                    r_protect[i] <= img_readonly;
                end
                if (img_mounted[i] && !img_size_nz) begin
                    r_pend_rd[i] <= 1'b0;
                    r_pend_wr[i] <= 1'b0;
                end else begin
                    r_pend_rd[i] <= (r_pend_rd[i] | w_acc_rd[i]) & ~w_clr_rd[i];
                    r_pend_wr[i] <= (r_pend_wr[i] | w_acc_wr[i]) & ~w_clr_wr[i];
                end
                if (w_acc_rd[i] || w_acc_wr[i])
                    r_sd_lba[i*LBA_W +: LBA_W] <= req_lba[i*LBA_W +: LBA_W];
                r_err[i] <= w_rej[i] | w_unmnt_err[i] | w_tmo_err[i];
            end
        end
    end

    // Handshake FSM: one strobe at a time, reads of a drive before its write
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_op_wr    <= 1'b0;
            r_timer    <= '0;
            r_ack_prev <= '0;
            r_sd_rd    <= '0;
            r_sd_wr    <= '0;
            r_done     <= '0;
        end else begin
            r_ack_prev <= sd_ack;
            r_done     <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pick[SEL_W]) begin
                        r_sel   <= w_pick[SEL_W-1:0];
                        r_op_wr <= !w_pick_rd;
                        r_sd_rd[w_pick[SEL_W-1:0]] <= w_pick_rd;
                        r_sd_wr[w_pick[SEL_W-1:0]] <= !w_pick_rd;
                        r_timer <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_ack_rise) begin
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_timer <= '0;
                        r_state <= XFER;
                    end else if (w_tmo) begin
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_ptr   <= next_ptr(r_sel);
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                XFER: begin
                    if (w_ack_fall) begin
                        r_done[r_sel] <= 1'b1;
                        r_ptr         <= next_ptr(r_sel);
                        r_state       <= IDLE;
                    end else if (w_tmo) begin
                        r_ptr   <= next_ptr(r_sel);
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sd_rd    = r_sd_rd;
    assign sd_wr    = r_sd_wr;
    assign sd_lba   = r_sd_lba;
    assign mounted  = r_mounted;
    assign protect  = r_protect;
    assign busy     = w_busy;
    assign cpu_wait = |w_busy;
    assign done     = r_done;
    assign err      = r_err;
endmodule

// File: tb/tb_sd_block_arbiter.sv
// Scoreboard bench for sd_block_arbiter: stimulus pushes expected strobe/done/err events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sd_block_arbiter;
    localparam int VDNUM = 2;
    localparam int LBA_W = 32;

    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [VDNUM-1:0]       req_rd = '0;
    logic [VDNUM-1:0]       req_wr = '0;
    logic [VDNUM*LBA_W-1:0] req_lba = '0;
    logic [VDNUM-1:0]       img_mounted = '0;
    logic                   img_readonly = 1'b0;
    logic                   img_size_nz = 1'b0;
    logic [VDNUM-1:0]       sd_ack = '0;
    logic [VDNUM-1:0]       sd_rd;
    logic [VDNUM-1:0]       sd_wr;
    logic [VDNUM*LBA_W-1:0] sd_lba;
    logic [VDNUM-1:0]       mounted;
    logic [VDNUM-1:0]       protect;
    logic [VDNUM-1:0]       busy;
    logic                   cpu_wait;
    logic [VDNUM-1:0]       done;
    logic [VDNUM-1:0]       err;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int excl_viol = 0;
    logic [63:0] exp_q[$];
    logic [VDNUM-1:0] prev_stb = '0;

    sd_block_arbiter #(.VDNUM(VDNUM), .LBA_W(LBA_W), .TIMEOUT_W(4)) dut (
        .clk_sys(clk), .reset_n(reset_n),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size_nz(img_size_nz),
        .sd_ack(sd_ack), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
        .mounted(mounted), .protect(protect), .busy(busy), .cpu_wait(cpu_wait),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [63:0] evt(input int kind, input logic [1:0] vec, input logic [31:0] lba);
        return {16'(kind), 14'd0, vec, lba};
    endfunction

    task automatic expect_evt(input int kind, input logic [1:0] vec, input logic [31:0] lba);
        exp_q.push_back(evt(kind, vec, lba));
    endtask

    task automatic got_evt(input logic [63:0] g);
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_event: got 0x%0h, expected no event", g);
        end else begin
            check("event", g, exp_q.pop_front());
        end
    endtask

    // Monitor: strobe rising edges, done and err pulses, in that order per cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if ($countones(sd_rd | sd_wr) > 1)
                excl_viol <= excl_viol + 1;
            if (((sd_rd | sd_wr) & ~prev_stb) != '0)
                got_evt(evt((sd_rd != '0) ? K_RD : K_WR, sd_rd | sd_wr,
                            sd_rd[1] | sd_wr[1] ? sd_lba[63:32] : sd_lba[31:0]));
            if (done != '0)
                got_evt(evt(K_DONE, done, 32'h0));
            if (err != '0)
                got_evt(evt(K_ERR, err, 32'h0));
        end
        prev_stb <= sd_rd | sd_wr;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mount(input logic [1:0] m, input logic ro, input logic nz);
        img_mounted = m; img_readonly = ro; img_size_nz = nz;
        tick();
        img_mounted = '0; img_readonly = 1'b0; img_size_nz = 1'b0;
    endtask

    task automatic req(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [31:0] l0, input logic [31:0] l1);
        req_rd = rd; req_wr = wr; req_lba = {l1, l0};
        tick();
        req_rd = '0; req_wr = '0;
    endtask

    task automatic serve(input int d, input int hold);
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if ((((sd_rd | sd_wr) >> d) & 2'b01) != 2'b00)
                seen = 1;
            else
                tick();
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL serve_wait: drive %0d got no strobe in 40 cycles, expected a strobe", d);
        end else begin
            sd_ack = sd_ack | (2'b01 << d);
            repeat (hold) tick();
            sd_ack = sd_ack & ~(2'b01 << d);
            tick();
            tick();
        end
    endtask

    initial begin
        int hi_cnt;
        tick();
        tick();
        check("rst_strobes", {sd_rd, sd_wr}, 0);
        check("rst_busy", {busy, cpu_wait}, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_mount", {mounted, protect}, 0);
        check("rst_lba", sd_lba, 0);
        reset_n = 1'b1;
        tick();

        mount(2'b11, 1'b0, 1'b1);
        check("mounted_rw", {mounted, protect}, 4'b1100);

        // Single read on drive 1, exact cycle timing
        expect_evt(K_RD, 2'b10, 32'h1234);
        expect_evt(K_DONE, 2'b10, 32'h0);
        req(2'b10, 2'b00, 32'h0, 32'h1234);
        check("t1_busy_k1", {busy, cpu_wait}, 3'b101);
        check("t1_no_strobe_k1", sd_rd, 2'b00);
        tick();
        check("t1_strobe_k2", sd_rd, 2'b10);
        check("t1_lba", sd_lba[63:32], 32'h1234);
        sd_ack = 2'b10;
        tick();
        check("t1_strobe_drop", sd_rd, 2'b00);
        tick();
        tick();
        sd_ack = 2'b00;
        tick();
        check("t1_done", done, 2'b10);
        tick();
        check("t1_done_clear", {done, cpu_wait}, 3'b000);

        // Round robin: pair, pair, drive 1 alone, pair
        for (int r = 0; r < 2; r++) begin
            expect_evt(K_RD, 2'b01, 32'hA0 + r);
            expect_evt(K_DONE, 2'b01, 32'h0);
            expect_evt(K_RD, 2'b10, 32'hB0 + r);
            expect_evt(K_DONE, 2'b10, 32'h0);
            req(2'b11, 2'b00, 32'hA0 + r, 32'hB0 + r);
            serve(0, 3);
            serve(1, 3);
        end
        expect_evt(K_RD, 2'b10, 32'hB7);
        expect_evt(K_DONE, 2'b10, 32'h0);
        req(2'b10, 2'b00, 32'h0, 32'hB7);
        serve(1, 2);
        expect_evt(K_RD, 2'b01, 32'hA9);
        expect_evt(K_DONE, 2'b01, 32'h0);
        expect_evt(K_RD, 2'b10, 32'hB9);
        expect_evt(K_DONE, 2'b10, 32'h0);
        req(2'b11, 2'b00, 32'hA9, 32'hB9);
        serve(0, 3);
        serve(1, 3);
        tick();

        // Write-protect and unmounted rejections
        mount(2'b01, 1'b1, 1'b1);
        check("protect0", {mounted, protect}, 4'b1101);
        expect_evt(K_ERR, 2'b01, 32'h0);
        req(2'b00, 2'b01, 32'hDEAD, 32'h0);
        check("wp_err", {err, busy}, 4'b0100);
        tick();
        check("wp_no_write", {sd_wr, err}, 4'b0000);
        mount(2'b10, 1'b0, 1'b0);
        check("unmounted1", mounted, 2'b01);
        expect_evt(K_ERR, 2'b10, 32'h0);
        req(2'b10, 2'b00, 32'h0, 32'hBEEF);
        check("unm_err", {err, busy}, 4'b1000);
        tick();
        check("unm_no_read", sd_rd, 2'b00);

        // Read + write together on drive 0: read first, then write
        mount(2'b11, 1'b0, 1'b1);
        expect_evt(K_RD, 2'b01, 32'hC0);
        expect_evt(K_DONE, 2'b01, 32'h0);
        expect_evt(K_WR, 2'b01, 32'hC0);
        expect_evt(K_DONE, 2'b01, 32'h0);
        req(2'b01, 2'b01, 32'hC0, 32'h0);
        serve(0, 3);
        serve(0, 3);
        tick();

        // Timeout on drive 1 (pointer now 1), then drive 0 served
        expect_evt(K_RD, 2'b10, 32'hD1);
        expect_evt(K_ERR, 2'b10, 32'h0);
        expect_evt(K_RD, 2'b01, 32'hD0);
        expect_evt(K_DONE, 2'b01, 32'h0);
        req(2'b11, 2'b00, 32'hD0, 32'hD1);
        tick();
        check("tmo_strobe", sd_rd, 2'b10);
        hi_cnt = 0;
        while (sd_rd[1] && hi_cnt < 40) begin
            hi_cnt++;
            tick();
        end
        check("tmo_len_15_16", 64'(hi_cnt >= 15 && hi_cnt <= 16), 1);
        serve(0, 3);
        tick();

        // Async reset in the middle of a transfer
        expect_evt(K_RD, 2'b10, 32'hE1);
        req(2'b10, 2'b00, 32'h0, 32'hE1);
        tick();
        sd_ack = 2'b10;
        tick();
        tick();
        check("xfer_busy", busy, 2'b10);
        reset_n = 1'b0;
        #1;
        check("arst_strobes", {sd_rd, sd_wr}, 0);
        check("arst_busy", {busy, cpu_wait}, 0);
        check("arst_mount", {mounted, protect, done, err}, 0);
        check("arst_lba", sd_lba, 0);
        sd_ack = 2'b00;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        mount(2'b11, 1'b0, 1'b1);
        expect_evt(K_RD, 2'b01, 32'hF0);
        expect_evt(K_DONE, 2'b01, 32'h0);
        req(2'b01, 2'b00, 32'hF0, 32'h0);
        serve(0, 3);

        repeat (5) tick();
        check("queue_empty", 64'(exp_q.size()), 0);
        check("strobe_exclusive", 64'(excl_viol), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
